// File: rtl/clb_cfg_pkg.sv
// ---------------------------------------------------------------------------
// clb_cfg_pkg : shared constants, FSM encoding and sizing helpers for the
//               CLB configuration loader.                          rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clb_cfg_pkg;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic int frame_bits(input int num_clb, input int lut_bits, input int mode_bits);
      return num_clb * (lut_bits + mode_bits);
   endfunction

   function automatic int frame_bytes(input int num_clb, input int lut_bits, input int mode_bits);
      return frame_bits(num_clb, lut_bits, mode_bits) / 8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_piso.sv
// ---------------------------------------------------------------------------
// cfg_piso : 8-bit parallel-load, MSB-first shift register.        rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfg_piso (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] din,
   output logic       sout
);

   logic [7:0] shreg;

   // Load wins over shift; zeros enter at the LSB so the output idles low.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= 8'h00;
      end else if (load) begin
         shreg <= din;
      end else if (shift) begin
         shreg <= {shreg[6:0], 1'b0};
      end
   end

   assign sout = shreg[7];

endmodule

`default_nettype wire

// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader : host byte-stream frame checker and bit-serial writer for
//                  the CLB configuration shadow chain.             rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

import clb_cfg_pkg::*;

module clb_cfg_loader #(
   parameter int         NUM_CLB   = 4,
   parameter int         LUT_BITS  = 32,
   parameter int         MODE_BITS = 2,
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       cfg_sdata,
   output logic       cfg_shift,
   output logic       cfg_latch,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int FRAME_BITS  = frame_bits(NUM_CLB, LUT_BITS, MODE_BITS);
   localparam int FRAME_BYTES = frame_bytes(NUM_CLB, LUT_BITS, MODE_BITS);
   localparam int BCNT_W      = clog2(FRAME_BYTES + 1);

   generate
      if ((FRAME_BITS % 8) != 0) begin : g_frame_bits_check
         $error("clb_cfg_loader: FRAME_BITS must be a multiple of 8");
      end
   endgenerate

   state_t            state;
   state_t            state_nx;
   logic [BCNT_W-1:0] byte_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        csum;
   logic [7:0]        rx_csum;
   logic              piso_load;
   logic              piso_sout;
   logic              is_sync;
   logic              payload_full;

   assign is_sync      = (in_data == SYNC_BYTE);
   assign payload_full = (byte_cnt == BCNT_W'(FRAME_BYTES));

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      piso_load = 1'b0;
      cfg_shift = 1'b0;
      cfg_latch = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && is_sync) state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (payload_full) begin
                  state_nx = ST_CHECK;
               end else begin
                  piso_load = 1'b1;
                  state_nx  = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            cfg_shift = 1'b1;
            if (bit_cnt == 3'd7) state_nx = ST_LOAD;
         end
         ST_CHECK: begin
            cfg_latch = (rx_csum == csum);
            state_nx  = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         byte_cnt <= '0;
         bit_cnt  <= 3'd0;
         csum     <= 8'h00;
         rx_csum  <= 8'h00;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            ST_IDLE: begin
               if (in_valid && is_sync) begin
                  done     <= 1'b0;
                  err      <= 1'b0;
                  csum     <= 8'h00;
                  byte_cnt <= '0;
               end
            end
            ST_LOAD: begin
               if (in_valid) begin
                  if (payload_full) begin
                     rx_csum <= in_data;
                  end else begin
                     csum     <= csum ^ in_data;
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            ST_SHIFT: bit_cnt <= bit_cnt + 3'd1;
            ST_CHECK: begin
               if (rx_csum == csum) done <= 1'b1;
               else                 err  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   cfg_piso u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (piso_load),
      .shift (cfg_shift),
      .din   (in_data),
      .sout  (piso_sout)
   );

   // Gate the data so the chain input is quiet whenever it is not sampling.
   assign cfg_sdata = cfg_shift & piso_sout;
   assign busy      = (state != ST_IDLE);

endmodule

`default_nettype wire
